axis_upsizer_8to32: RTL

Downstream stage of the 4096-deep byte FIFO. It consumes the FIFO's 8-bit AXI-Stream master output (data, valid, last) and packs consecutive bytes into 32-bit AXI-Stream words with a byte-qualifying keep mask. A packet boundary (tlast) flushes a partial word. It also maintains a running count of completed packets. The 32-bit side feeds word-oriented consumers (DMA/bus bridge) in the same clock domain.

---
 rtl/axis_upsizer_8to32.sv | 132 +++++++++++++
 1 files changed

// File: rtl/axis_upsizer_8to32.sv
// Packs an 8-bit AXI-Stream into 32-bit words with a byte keep mask.
// A tlast byte flushes a partial word, and delivered packets are counted.
module axis_upsizer_8to32 #(
    parameter int BYTE_ORDER = 0,
    parameter int CNT_W      = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] pkt_count
);

    typedef enum logic [1:0] {FILL0 = 2'd0, FILL1 = 2'd1, FILL2 = 2'd2, FILL3 = 2'd3} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         idx;
    logic [23:0]        hold_reg;
    logic [31:0]        tdata_reg;
    logic [3:0]         tkeep_reg;
    logic               tvalid_reg;
    logic               tlast_reg;
    logic [CNT_W-1:0]   pkt_count_reg;

    logic               s_ready;
    logic               s_fire;
    logic               m_fire;
    logic               word_done;
    logic [7:0]         lane_data [4];
    logic [3:0]         lane_keep;
    logic [31:0]        word_next;
    logic [3:0]         keep_next;

    assign idx       = state_reg;
    assign s_ready   = ~areset & (~tvalid_reg | m_axis_tready);
    assign s_fire    = s_axis_tvalid & s_ready;
    assign m_fire    = tvalid_reg & m_axis_tready;
    assign word_done = s_fire & ((state_reg == FILL3) | s_axis_tlast);

    // Lanes below idx come from the holding register, lane idx is the live byte,
    // lanes above idx are zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            if (gi < 3) begin : g_held
                assign lane_data[gi] = (LANE < idx)  ? hold_reg[8*gi +: 8] :
                                       (LANE == idx) ? s_axis_tdata : 8'd0;
            end else begin : g_top
                assign lane_data[gi] = (LANE == idx) ? s_axis_tdata : 8'd0;
            end
            assign lane_keep[gi] = (LANE <= idx);

            if (BYTE_ORDER == 0) begin : g_fwd
                assign word_next[8*gi +: 8] = lane_data[gi];
                assign keep_next[gi]        = lane_keep[gi];
            end else begin : g_rev
                assign word_next[8*(3-gi) +: 8] = lane_data[gi];
                assign keep_next[3-gi]          = lane_keep[gi];
            end
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg <= FILL0;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (word_done) begin
            state_next = FILL0;
        end else if (s_fire) begin
            state_next = state_t'(idx + 2'd1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            hold_reg <= 24'd0;
        end else if (s_fire && !word_done) begin
            for (int i = 0; i < 3; i++) begin
                if (idx == 2'(i)) begin
                    hold_reg[8*i +: 8] <= s_axis_tdata;
                end
            end
        end
    end

    // A completing byte may load while the previous word drains in the same cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tdata_reg  <= 32'd0;
            tkeep_reg  <= 4'd0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else if (word_done) begin
            tdata_reg  <= word_next;
            tkeep_reg  <= keep_next;
            tvalid_reg <= 1'b1;
            tlast_reg  <= s_axis_tlast;
        end else if (m_fire) begin
            tvalid_reg <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_count_reg <= '0;
        end else if (m_fire && tlast_reg) begin
            pkt_count_reg <= pkt_count_reg + 1'b1;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tkeep  = tkeep_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;
    assign pkt_count     = pkt_count_reg;

endmodule
